ir_key_event_decoder: RTL
=========================

IR_KEY_EVENT_DECODER -- requirements
Module: ir_key_event_decoder

Interface
REQ-001 Parameters SHALL be (name, default, meaning): RAW_W, 16, raw frame width.
REQ-002 KEY_W, 8, decoded key code width.
REQ-003 NUM_KEYS, 8, lookup table entries, 1..16.
REQ-004 FIFO_DEPTH, 4, event FIFO entries, power of two, >=2.
REQ-005 REPEAT_FRAMES, 4, consecutive same-key frames per REPEAT event after PRESS.
REQ-006 RELEASE_TIMEOUT, 1000, clk cycles without a same-key frame before RELEASE.
REQ-007 Ports SHALL be (name direction width meaning): clk in 1 single clock, all logic on rising edge.
REQ-008 rst_n in 1 reset, synchronous, active-low.
REQ-009 latch in 1 frame strobe, clk-synchronous; rising edge marks raw_in valid.
REQ-010 raw_in in RAW_W raw frame code.
REQ-011 cfg_we in 1 table write enable; cfg_idx in 4 entry index; cfg_code in RAW_W match code; cfg_key in KEY_W decoded key; cfg_en in 1 entry enable.
REQ-012 out_valid out 1 event available; out_ready in 1 consumer accept.
REQ-013 out_key out KEY_W event key; out_type out 2 event type: 00 PRESS, 01 REPEAT, 10 RELEASE.
REQ-014 held out 1 a key is currently held; ovf out 1 sticky FIFO overflow; drop out 1 sticky dropped frame.

Function
REQ-015 Frame capture SHALL occur in cycle E where latch=1 and latch registered from the prior cycle=0; raw_in captured that cycle; no capture on level-high or falling edge.
REQ-016 Lookup SHALL match the captured code against enabled entries; lowest matching index wins; no match = unmatched frame, silently ignored (no event, no state change, timeout not reset).
REQ-017 Table writes with cfg_idx>=NUM_KEYS SHALL be ignored; valid writes apply to frames captured in the following cycle or later.
REQ-018 FSM states SHALL be IDLE, HELD, SWITCH.
REQ-019 IDLE + matched key K: push PRESS(K), go HELD, cur_key=K, rep_cnt=0, timer=0.
REQ-020 HELD + matched frame equal cur_key: timer=0, rep_cnt+1; when rep_cnt reaches REPEAT_FRAMES push REPEAT(cur_key) and rep_cnt=0.
REQ-021 HELD + matched key J != cur_key: push RELEASE(cur_key), go SWITCH; next cycle push PRESS(J), cur_key=J, rep_cnt=0, timer=0, go HELD.
REQ-022 HELD + no same-key frame: timer increments each cycle; at timer==RELEASE_TIMEOUT push RELEASE(cur_key), go IDLE.
REQ-023 Timeout and same-key frame in the same cycle: frame wins, no RELEASE.
REQ-024 Frame edge arriving while in SWITCH SHALL be discarded and set drop.
REQ-025 held SHALL be 1 in HELD and SWITCH, 0 in IDLE.
REQ-026 Event latency: push occurs at cycle E+1; with FIFO empty, out_valid=1 and event on out_key/out_type at E+2.
REQ-027 FIFO is first-word-fall-through; pop when out_valid&&out_ready; out_key/out_type stable while out_valid&&!out_ready.
REQ-028 Push when full and no pop same cycle: event dropped, ovf set; push with simultaneous pop when full: accepted.
REQ-029 Timers and counters SHALL saturate, never wrap.

Reset
REQ-030 rst_n=0 at a clk edge: FSM=IDLE, FIFO empty, out_valid=0, out_key=0, out_type=0, held=0, ovf=0, drop=0, counters 0, latch history 0.
REQ-031 Reset table: entries 0..7 enabled with (code,key) 0x0A0B->0x01, 0x0A02->0x02, 0x0A04->0x05, 0x0A06->0x06, 0x0A08->0x07, 0x0A10->0x08, 0x0A0A->0x09, 0x0A12->0x0A; entries >=8 disabled, zero.
REQ-032 Reset mid-operation SHALL discard held key and queued events without emitting RELEASE.

Verification
REQ-033 Single press: raw_in=0x0A04, latch edge at E, out_ready=1 -> out_valid at E+2, out_key=0x05, out_type=00, held=1; no further frames -> RELEASE(0x05) after 1000 cycles, held=0.
REQ-034 Repeat: 9 frames 0x0A0A, 20 cycles apart -> PRESS(0x09), REPEAT, REPEAT (after frames 5 and 9), no RELEASE before timeout.
REQ-035 Key switch: HELD on 0x0A0B, frame 0x0A12 -> RELEASE(0x01) then PRESS(0x0A) on consecutive cycles; edge during SWITCH -> drop=1.
REQ-036 Overflow: out_ready=0, 5 alternating-key frames -> 4 events retained in order, ovf=1; then out_ready=1 drains 4, out_valid=0.
REQ-037 Config/unmatched: frame 0x1234 -> no event; write idx 8 (NUM_KEYS=8) ignored; write idx 3 code 0x1234 key 0x40 -> next 0x1234 frame yields PRESS(0x40); reset mid-HELD -> out_valid=0, held=0, table restored.

Source files
------------

// File: rtl/ir_key_event_decoder.sv
// IR key event decoder: captures raw frames on latch edges, maps them through a
// configurable lookup table and emits PRESS/REPEAT/RELEASE events into a FWFT FIFO.
module ir_key_event_decoder #(
  parameter int RAW_W           = 16,
  parameter int KEY_W           = 8,
  parameter int NUM_KEYS        = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_FRAMES   = 4,
  parameter int RELEASE_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             latch,
  input  logic [RAW_W-1:0] raw_in,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_idx,
  input  logic [RAW_W-1:0] cfg_code,
  input  logic [KEY_W-1:0] cfg_key,
  input  logic             cfg_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KEY_W-1:0] out_key,
  output logic [1:0]       out_type,
  output logic             held,
  output logic             ovf,
  output logic             drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  localparam int TMR_W = $clog2(RELEASE_TIMEOUT + 1);

  localparam logic [4:0]       NK       = 5'(NUM_KEYS);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);
  localparam logic [TMR_W-1:0] TMO      = TMR_W'(RELEASE_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_REPEAT  = 2'b01;
  localparam logic [1:0] EV_RELEASE = 2'b10;

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_HELD = 2'b01, S_SWITCH = 2'b10} state_t;

  function automatic logic [RAW_W-1:0] dflt_code(input logic [3:0] idx);
    case (idx)
      4'd0:    dflt_code = RAW_W'(16'h0A0B);
      4'd1:    dflt_code = RAW_W'(16'h0A02);
      4'd2:    dflt_code = RAW_W'(16'h0A04);
      4'd3:    dflt_code = RAW_W'(16'h0A06);
      4'd4:    dflt_code = RAW_W'(16'h0A08);
      4'd5:    dflt_code = RAW_W'(16'h0A10);
      4'd6:    dflt_code = RAW_W'(16'h0A0A);
      4'd7:    dflt_code = RAW_W'(16'h0A12);
      default: dflt_code = '0;
    endcase
  endfunction

  function automatic logic [KEY_W-1:0] dflt_key(input logic [3:0] idx);
    case (idx)
      4'd0:    dflt_key = KEY_W'(8'h01);
      4'd1:    dflt_key = KEY_W'(8'h02);
      4'd2:    dflt_key = KEY_W'(8'h05);
      4'd3:    dflt_key = KEY_W'(8'h06);
      4'd4:    dflt_key = KEY_W'(8'h07);
      4'd5:    dflt_key = KEY_W'(8'h08);
      4'd6:    dflt_key = KEY_W'(8'h09);
      4'd7:    dflt_key = KEY_W'(8'h0A);
      default: dflt_key = '0;
    endcase
  endfunction

  function automatic logic dflt_en(input logic [3:0] idx);
    dflt_en = ({1'b0, idx} < 5'd8) && ({1'b0, idx} < NK);
  endfunction

  // Lookup table (16 slots of storage; only the first NUM_KEYS are writable or searched)
  logic [RAW_W-1:0] r_tbl_code [16];
  logic [KEY_W-1:0] r_tbl_key  [16];
  logic [15:0]      r_tbl_en;

  logic             r_latch_d;
  logic             r_cap_valid;
  logic [RAW_W-1:0] r_cap_code;
  logic             r_drop;

  state_t           r_state;
  logic [KEY_W-1:0] r_cur_key;
  logic [KEY_W-1:0] r_pend_key;
  logic [REP_W-1:0] r_rep;
  logic [TMR_W-1:0] r_timer;
  logic             r_held;

  logic [KEY_W-1:0] r_fifo_key  [FIFO_DEPTH];
  logic [1:0]       r_fifo_type [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_ovf;

  logic             w_edge;
  logic             w_hit;
  logic [KEY_W-1:0] w_hit_key;
  logic             w_frame;
  logic             w_same;
  logic             w_diff;
  logic             w_tmo;
  logic             w_rep_last;
  logic             w_push;
  logic [KEY_W-1:0] w_push_key;
  logic [1:0]       w_push_type;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;

  assign w_edge     = latch && !r_latch_d;
  assign w_frame    = r_cap_valid && w_hit;
  assign w_same     = w_frame && (w_hit_key == r_cur_key);
  assign w_diff     = w_frame && (w_hit_key != r_cur_key);
  assign w_tmo      = (r_timer == TMO);
  assign w_rep_last = (r_rep >= REP_LAST);

  // Table configuration; out-of-range indices are ignored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_tbl_code[i] <= dflt_code(4'(i));
        r_tbl_key[i]  <= dflt_key(4'(i));
        r_tbl_en[i]   <= dflt_en(4'(i));
      end
    end else if (cfg_we && ({1'b0, cfg_idx} < NK)) begin
      r_tbl_code[cfg_idx] <= cfg_code;
      r_tbl_key[cfg_idx]  <= cfg_key;
      r_tbl_en[cfg_idx]   <= cfg_en;
    end
  end

  // Frame capture on the latch rising edge; edges seen during SWITCH are dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_latch_d   <= 1'b0;
      r_cap_valid <= 1'b0;
      r_cap_code  <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_latch_d   <= latch;
      r_cap_valid <= w_edge && (r_state != S_SWITCH);
      if (w_edge) begin
        r_cap_code <= raw_in;
      end
      if (w_edge && (r_state == S_SWITCH)) begin
        r_drop <= 1'b1;
      end
    end
  end

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    w_hit     = 1'b0;
    w_hit_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      w_hit_key = (r_tbl_en[i] && (r_tbl_code[i] == r_cap_code)) ? r_tbl_key[i] : w_hit_key;
      w_hit     = w_hit | (r_tbl_en[i] && (r_tbl_code[i] == r_cap_code));
    end
  end

  // Event generation; a same-key frame takes priority over the release timeout
  always_comb begin
    w_push      = 1'b0;
    w_push_key  = r_cur_key;
    w_push_type = EV_PRESS;
    case (r_state)
      S_IDLE: begin
        if (w_frame) begin
          w_push     = 1'b1;
          w_push_key = w_hit_key;
        end else begin
          w_push = 1'b0;
        end
      end
      S_HELD: begin
        if (w_diff) begin
          w_push      = 1'b1;
          w_push_type = EV_RELEASE;
        end else if (w_same) begin
          w_push      = w_rep_last;
          w_push_type = EV_REPEAT;
        end else if (w_tmo) begin
          w_push      = 1'b1;
          w_push_type = EV_RELEASE;
        end else begin
          w_push = 1'b0;
        end
      end
      S_SWITCH: begin
        w_push     = 1'b1;
        w_push_key = r_pend_key;
      end
      default: begin
        w_push = 1'b0;
      end
    endcase
  end

  // Key state machine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cur_key  <= '0;
      r_pend_key <= '0;
      r_rep      <= '0;
      r_timer    <= '0;
      r_held     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_frame) begin
            r_state   <= S_HELD;
            r_cur_key <= w_hit_key;
            r_rep     <= '0;
            r_timer   <= '0;
            r_held    <= 1'b1;
          end
        end
        S_HELD: begin
          if (w_diff) begin
            r_state    <= S_SWITCH;
            r_pend_key <= w_hit_key;
          end else if (w_same) begin
            r_timer <= '0;
            r_rep   <= w_rep_last ? '0 : r_rep + 1'b1;
          end else if (w_tmo) begin
            r_state <= S_IDLE;
            r_held  <= 1'b0;
          end else begin
            r_timer <= (r_timer == TMR_MAX) ? r_timer : r_timer + 1'b1;
          end
        end
        S_SWITCH: begin
          r_state   <= S_HELD;
          r_cur_key <= r_pend_key;
          r_rep     <= '0;
          r_timer   <= '0;
          r_held    <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign w_pop  = out_valid && out_ready;
  assign w_full = (r_count == DEPTH_C);
  assign w_wr   = w_push && (!w_full || w_pop);

  // Event FIFO; a push into a full FIFO is accepted only if a pop frees a slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_key[i]  <= '0;
        r_fifo_type[i] <= 2'b00;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_fifo_key[r_wr_ptr]  <= w_push_key;
        r_fifo_type[r_wr_ptr] <= w_push_type;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign out_valid = (r_count != '0);
  assign out_key   = r_fifo_key[r_rd_ptr];
  assign out_type  = r_fifo_type[r_rd_ptr];
  assign held      = r_held;
  assign ovf       = r_ovf;
  assign drop      = r_drop;

endmodule
